seq_addsub: RTL and testbench
=============================

Name: seq_addsub

Overview:
- Parametrised, multi-cycle successor to the 8-bit ripple-carry add/subtract datapath.
- Adds or subtracts two WIDTH-bit operands SLICE bits per clock through one shared SLICE-bit ripple slice.
- Flags: carry/borrow-out and signed overflow.
- Valid/ready on input and output, so it sits between a register-file/operand stage and a result consumer that may stall.

Parameters:
- WIDTH, 8, operand/result width in bits (>=2).
- SLICE, 2, bits processed per cycle. WIDTH % SLICE must be 0, else elaboration error. N = WIDTH/SLICE slice cycles.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operands/mode valid
- in_ready  output  1  block can accept an operation
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- mode  input  1  0 = add (A+B+c_in); 1 = subtract (A-B-c_in)
- c_in  input  1  carry-in (add) / borrow-in (sub)
- out_valid  output  1  result valid
- out_ready  input  1  consumer takes result
- s  output  WIDTH  result
- c_out  output  1  raw carry out of the MSB
- ovf  output  1  two's-complement overflow

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, in_ready=1, out_valid=0.
  - s=0, c_out=0, ovf=0, internal counter/carry=0.
- Arithmetic:
  - Every operation is A + B' + cin0, where add uses B'=b and cin0=c_in; sub uses B'=~b and cin0=~c_in.
  - c_out is the true carry out of bit WIDTH-1, so for sub c_out=1 means no borrow.
  - ovf = carry into bit WIDTH-1 XOR carry out of bit WIDTH-1. It is captured inside the last slice.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid & in_ready at edge t: latch a, B', cin0 into the working carry; cnt=0; state to RUN.
- RUN:
  - in_ready=0.
  - Each edge processes slice cnt (bits cnt*SLICE+SLICE-1 .. cnt*SLICE).
  - The sum slice is written into s[slice], the slice carry-out goes to the carry register, and cnt increments.
  - When cnt==N-1: also load c_out and ovf, then go to DONE.
- DONE:
  - out_valid=1; s, c_out and ovf are held stable.
  - When out_ready=1 at an edge: out_valid to 0, state to IDLE.
  - No new operation is accepted in the same edge; in_ready=0 throughout DONE.
- Latency and throughput:
  - Accept at edge t gives out_valid=1 after edge t+N.
  - With out_ready held at 1, the next accept is possible at edge t+N+2.
  - SLICE==WIDTH gives N=1, i.e. a single RUN cycle.
- Operand capture: a, b, mode and c_in may change freely after the accept edge, since the latched copies are used.
- Contents of s during RUN are partial and not guaranteed. Consumers use s only while out_valid=1.
- in_valid while not IDLE is ignored; there is no queueing.
- out_ready while not DONE is ignored.
- Reset mid-RUN or mid-DONE:
  - The operation is aborted and the result lost.
  - All outputs return to their reset values immediately, asynchronously.
  - After rst_n deasserts, the first accept is possible on the next edge.

Test Plan:
- WIDTH=8, SLICE=2 (N=4), add 0x7F+0x01, c_in=0:
  - out_valid rises exactly 4 edges after accept.
  - s=0x80, c_out=0, ovf=1.
- Sub 0x05-0x07, c_in=0:
  - s=0xFE, c_out=0 (borrow), ovf=0.
- Sub 0x80-0x01, c_in=0 -> s=0x7F, c_out=1, ovf=1.
- Add 0xFF+0x00, c_in=1 -> s=0x00, c_out=1, ovf=0.
- Sub 0x10-0x00, c_in=1 -> s=0x0F, c_out=1, ovf=0.
- Backpressure:
  - Hold out_ready=0 for 5 cycles after out_valid while pulsing in_valid with new operands.
  - Required: s/c_out/ovf unchanged, in_ready=0, no new accept.
  - Then set out_ready=1: IDLE next edge, and the new operation is accepted on the following edge.
- Reset: assert rst_n=0 at cnt=2 of an operation -> out_valid=0, s=0, in_ready=1 immediately.
- Re-run with WIDTH=16, SLICE=16 and WIDTH=16, SLICE=4: random a/b/mode/c_in vs reference model.
  - Latency is 1 and 4 edges respectively.

Source files
------------

// File: rtl/seq_addsub.sv
// Multi-cycle add/subtract: WIDTH-bit operands pass SLICE bits per clock through one
// shared ripple slice, with valid/ready handshakes on both the operand and result sides.
module seq_addsub #(
  parameter int WIDTH = 8,
  parameter int SLICE = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             mode,
  input  logic             c_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             c_out,
  output logic             ovf
);

  localparam int N     = WIDTH / SLICE;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

  generate
    if (WIDTH < 2 || SLICE < 1 || SLICE > WIDTH || (WIDTH % SLICE) != 0) begin : g_bad_params
      $error("seq_addsub: WIDTH must be >= 2 and an integer multiple of SLICE");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               carry_q, carry_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [WIDTH-1:0]   s_q, s_d;
  logic               c_out_q, c_out_d;
  logic               ovf_q, ovf_d;

  logic [SLICE-1:0]   a_sl, b_sl, sum_sl;
  logic [SLICE:0]     rc;

  // b_q already holds B' (inverted for subtract), so the slice is always a plain adder.
  assign a_sl  = a_q[cnt_q*SLICE +: SLICE];
  assign b_sl  = b_q[cnt_q*SLICE +: SLICE];
  assign rc[0] = carry_q;

  genvar gi;
  generate
    for (gi = 0; gi < SLICE; gi++) begin : g_ripple
      assign sum_sl[gi] = a_sl[gi] ^ b_sl[gi] ^ rc[gi];
      assign rc[gi+1]   = (a_sl[gi] & b_sl[gi]) | (a_sl[gi] & rc[gi]) | (b_sl[gi] & rc[gi]);
    end
  endgenerate

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    a_d     = a_q;
    b_d     = b_q;
    s_d     = s_q;
    c_out_d = c_out_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = mode ? ~b : b;
          carry_d = mode ? ~c_in : c_in;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        s_d[cnt_q*SLICE +: SLICE] = sum_sl;
        carry_d = rc[SLICE];
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          // On the top slice rc[SLICE-1] is the carry into bit WIDTH-1.
          c_out_d = rc[SLICE];
          ovf_d   = rc[SLICE] ^ rc[SLICE-1];
          cnt_d   = '0;
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      s_q     <= '0;
      c_out_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      s_q     <= s_d;
      c_out_q <= c_out_d;
      ovf_q   <= ovf_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign s         = s_q;
  assign c_out     = c_out_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_seq_addsub.sv
// Bench for seq_addsub: directed and random operations on 8/2, 16/16 and 16/4 instances,
// checked against an integer-arithmetic reference model.
module tb_seq_addsub;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  logic       iv8, ir8, m8, ci8, ov8, or8, co8, of8;
  logic [7:0] a8, b8, s8;

  logic        iv16, m16, ci16, or16;
  logic [15:0] a16, b16;
  logic        ir_w, ov_w, co_w, of_w;
  logic [15:0] s_w;
  logic        ir_n, ov_n, co_n, of_n;
  logic [15:0] s_n;

  int passed = 0;
  int failed = 0;
  int total  = 0;

  seq_addsub #(.WIDTH(8), .SLICE(2)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8), .a(a8), .b(b8),
    .mode(m8), .c_in(ci8), .out_valid(ov8), .out_ready(or8), .s(s8), .c_out(co8), .ovf(of8)
  );

  seq_addsub #(.WIDTH(16), .SLICE(16)) dut16w (
    .clk(clk), .rst_n(rst_n), .in_valid(iv16), .in_ready(ir_w), .a(a16), .b(b16),
    .mode(m16), .c_in(ci16), .out_valid(ov_w), .out_ready(or16), .s(s_w), .c_out(co_w), .ovf(of_w)
  );

  seq_addsub #(.WIDTH(16), .SLICE(4)) dut16n (
    .clk(clk), .rst_n(rst_n), .in_valid(iv16), .in_ready(ir_n), .a(a16), .b(b16),
    .mode(m16), .c_in(ci16), .out_valid(ov_n), .out_ready(or16), .s(s_n), .c_out(co_n), .ovf(of_n)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: true integer add/subtract; overflow means the signed result is out of range.
  function automatic void ref_op(input int w, input longint ua, input longint ub,
                                 input bit md, input bit cin,
                                 output longint rs, output bit rco, output bit rov);
    longint m, half, sa, sb, c, full, sres;
    m    = longint'(1) << w;
    half = m >> 1;
    c    = cin ? 1 : 0;
    sa   = (ua >= half) ? ua - m : ua;
    sb   = (ub >= half) ? ub - m : ub;
    if (!md) begin
      full = ua + ub + c;
      rco  = (full >= m);
      sres = sa + sb + c;
    end else begin
      full = ua - ub - c;
      rco  = (full >= 0);
      sres = sa - sb - c;
    end
    rs  = full & (m - 1);
    rov = (sres < -half) || (sres >= half);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic scramble8();
    a8 = 8'($urandom); b8 = 8'($urandom); m8 = 1'($urandom); ci8 = 1'($urandom);
  endtask

  // Waits for out_valid on the 8-bit instance and checks latency and result fields.
  task automatic finish8(input string tag, input longint es, input bit eco, input bit eov);
    int n;
    n = 0;
    while (!ov8 && n < 16) begin
      tick();
      n++;
    end
    chk({tag, "/latency"}, n, 4);
    chk({tag, "/s"}, s8, es[7:0]);
    chk({tag, "/c_out"}, co8, eco);
    chk({tag, "/ovf"}, of8, eov);
    chk({tag, "/in_ready_done"}, ir8, 1'b0);
  endtask

  task automatic op8(input string tag, input logic [7:0] ua, input logic [7:0] ub,
                     input logic md, input logic ci);
    longint es;
    bit eco, eov;
    ref_op(8, ua, ub, md, ci, es, eco, eov);
    chk({tag, "/in_ready_idle"}, ir8, 1'b1);
    a8 = ua; b8 = ub; m8 = md; ci8 = ci; iv8 = 1'b1;
    tick();
    iv8 = 1'b0;
    scramble8();
    chk({tag, "/in_ready_run"}, ir8, 1'b0);
    finish8(tag, es, eco, eov);
    or8 = 1'b1;
    tick();
    or8 = 1'b0;
    chk({tag, "/out_valid_drop"}, ov8, 1'b0);
    chk({tag, "/in_ready_back"}, ir8, 1'b1);
  endtask

  initial begin
    longint es, es2;
    bit eco, eov, eco2, eov2;
    int lw, ln;
    logic [7:0] hold_a, hold_b;

    rst_n = 1'b1;
    iv8 = 0; or8 = 0; a8 = 0; b8 = 0; m8 = 0; ci8 = 0;
    iv16 = 0; or16 = 0; a16 = 0; b16 = 0; m16 = 0; ci16 = 0;
    #1 rst_n = 1'b0;
    #3;
    chk("reset8/in_ready", ir8, 1'b1);
    chk("reset8/out_valid", ov8, 1'b0);
    chk("reset8/s", s8, 8'h00);
    chk("reset8/c_out", co8, 1'b0);
    chk("reset8/ovf", of8, 1'b0);
    chk("reset16w/in_ready", ir_w, 1'b1);
    chk("reset16w/out_valid", ov_w, 1'b0);
    chk("reset16w/s", s_w, 16'h0000);
    chk("reset16n/in_ready", ir_n, 1'b1);
    chk("reset16n/out_valid", ov_n, 1'b0);
    chk("reset16n/s", s_n, 16'h0000);
    tick();
    tick();
    #2 rst_n = 1'b1;
    tick();

    op8("add_7f_01", 8'h7F, 8'h01, 1'b0, 1'b0);
    op8("sub_05_07", 8'h05, 8'h07, 1'b1, 1'b0);
    op8("sub_80_01", 8'h80, 8'h01, 1'b1, 1'b0);
    op8("add_ff_00_c", 8'hFF, 8'h00, 1'b0, 1'b1);
    op8("sub_10_00_c", 8'h10, 8'h00, 1'b1, 1'b1);
    for (int i = 0; i < 10; i++) begin
      op8($sformatf("rand8_%0d", i), 8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom));
    end

    // Backpressure: result must hold while in_valid pulses with other operands.
    ref_op(8, 8'h3C, 8'h5A, 1'b0, 1'b1, es, eco, eov);
    a8 = 8'h3C; b8 = 8'h5A; m8 = 1'b0; ci8 = 1'b1; iv8 = 1'b1;
    tick();
    iv8 = 1'b0;
    scramble8();
    finish8("bp_first", es, eco, eov);
    for (int k = 0; k < 5; k++) begin
      iv8 = ~iv8;
      scramble8();
      tick();
      chk($sformatf("bp_hold%0d/out_valid", k), ov8, 1'b1);
      chk($sformatf("bp_hold%0d/in_ready", k), ir8, 1'b0);
      chk($sformatf("bp_hold%0d/s", k), s8, es[7:0]);
      chk($sformatf("bp_hold%0d/c_out", k), co8, eco);
      chk($sformatf("bp_hold%0d/ovf", k), of8, eov);
    end
    hold_a = 8'h12; hold_b = 8'h34;
    ref_op(8, hold_a, hold_b, 1'b1, 1'b0, es2, eco2, eov2);
    a8 = hold_a; b8 = hold_b; m8 = 1'b1; ci8 = 1'b0; iv8 = 1'b1; or8 = 1'b1;
    tick();
    or8 = 1'b0;
    chk("bp_release/out_valid", ov8, 1'b0);
    chk("bp_release/in_ready", ir8, 1'b1);
    tick();
    iv8 = 1'b0;
    scramble8();
    chk("bp_accept/in_ready", ir8, 1'b0);
    finish8("bp_second", es2, eco2, eov2);
    or8 = 1'b1;
    tick();
    or8 = 1'b0;

    // Asynchronous reset with the operation at cnt=2.
    a8 = 8'hFF; b8 = 8'h00; m8 = 1'b0; ci8 = 1'b0; iv8 = 1'b1;
    tick();
    iv8 = 1'b0;
    tick();
    tick();
    #2 rst_n = 1'b0;
    #1;
    chk("midrun_rst/out_valid", ov8, 1'b0);
    chk("midrun_rst/in_ready", ir8, 1'b1);
    chk("midrun_rst/s", s8, 8'h00);
    chk("midrun_rst/c_out", co8, 1'b0);
    chk("midrun_rst/ovf", of8, 1'b0);
    rst_n = 1'b1;
    ref_op(8, 8'hA5, 8'h5B, 1'b0, 1'b0, es, eco, eov);
    a8 = 8'hA5; b8 = 8'h5B; m8 = 1'b0; ci8 = 1'b0; iv8 = 1'b1;
    tick();
    iv8 = 1'b0;
    scramble8();
    chk("post_rst_accept/in_ready", ir8, 1'b0);
    finish8("post_rst", es, eco, eov);
    or8 = 1'b1;
    tick();
    or8 = 1'b0;

    // 16-bit instances share operands: SLICE=16 (latency 1) and SLICE=4 (latency 4).
    for (int i = 0; i < 24; i++) begin
      case (i)
        0: begin a16 = 16'hFFFF; b16 = 16'h0000; m16 = 1'b0; ci16 = 1'b1; end
        1: begin a16 = 16'h8000; b16 = 16'h0001; m16 = 1'b1; ci16 = 1'b0; end
        2: begin a16 = 16'h7FFF; b16 = 16'h7FFF; m16 = 1'b0; ci16 = 1'b1; end
        default: begin
          a16 = 16'($urandom); b16 = 16'($urandom); m16 = 1'($urandom); ci16 = 1'($urandom);
        end
      endcase
      ref_op(16, a16, b16, m16, ci16, es, eco, eov);
      chk($sformatf("r16_%0d/w_in_ready", i), ir_w, 1'b1);
      chk($sformatf("r16_%0d/n_in_ready", i), ir_n, 1'b1);
      iv16 = 1'b1;
      tick();
      iv16 = 1'b0;
      a16 = 16'($urandom); b16 = 16'($urandom); m16 = 1'($urandom); ci16 = 1'($urandom);
      lw = -1;
      ln = -1;
      for (int e = 1; e <= 12 && (lw < 0 || ln < 0); e++) begin
        tick();
        if (lw < 0 && ov_w) lw = e;
        if (ln < 0 && ov_n) ln = e;
      end
      chk($sformatf("r16_%0d/w_latency", i), lw, 1);
      chk($sformatf("r16_%0d/n_latency", i), ln, 4);
      chk($sformatf("r16_%0d/w_s", i), s_w, es[15:0]);
      chk($sformatf("r16_%0d/w_c_out", i), co_w, eco);
      chk($sformatf("r16_%0d/w_ovf", i), of_w, eov);
      chk($sformatf("r16_%0d/n_s", i), s_n, es[15:0]);
      chk($sformatf("r16_%0d/n_c_out", i), co_n, eco);
      chk($sformatf("r16_%0d/n_ovf", i), of_n, eov);
      or16 = 1'b1;
      tick();
      or16 = 1'b0;
      chk($sformatf("r16_%0d/w_back_idle", i), ir_w, 1'b1);
      chk($sformatf("r16_%0d/n_back_idle", i), ir_n, 1'b1);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
